// File: rtl/ioctl_pkg.sv
// Shared command codes and FSM state encoding for the ioctl SPI download path.
package ioctl_pkg;

    localparam logic [7:0] CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

    typedef enum logic [1:0] {
        S_CMD,
        S_CTRL,
        S_INDEX,
        S_DATA
    } ioctl_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampled SPI slave byte receiver: synchronisers, SCK rise detect, MSB-first shifter.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_di,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       ss_active
);

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, di_sync;
    logic                   sck_prev;
    logic                   armed;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;
    logic                   sck_s, ss_s, di_s, sck_rise;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign di_s     = di_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;

    assign ss_active  = ~ss_s;
    assign rx_byte    = {shreg, di_s};
    assign byte_valid = sck_rise & ~ss_s & armed & (bit_cnt == 3'd7);

    // SS chain resets low so a frame cut by reset stays ignored until SS2 is
    // genuinely seen high again; only then is the receiver armed.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync <= '0;
            ss_sync  <= '0;
            di_sync  <= '0;
            sck_prev <= 1'b0;
            armed    <= 1'b0;
            bit_cnt  <= 3'd0;
            shreg    <= 7'd0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ss_sync  <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            di_sync  <= {di_sync[SYNC_STAGES-2:0], spi_di};
            sck_prev <= sck_s;
            if (ss_s) begin
                armed   <= 1'b1;
                bit_cnt <= 3'd0;
            end else if (sck_rise && armed) begin
                shreg   <= {shreg[5:0], di_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/ioctl_spi_loader.sv
// MiST file-transfer SPI stream to ioctl download interface.
// Optional running checksum output under IOCTL_SPI_LOADER_CHECKSUM_EN.
module ioctl_spi_loader
    import ioctl_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int START_ADDR  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              SPI_SCK,
    input  logic              SPI_SS2,
    input  logic              SPI_DI,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout
`ifdef IOCTL_SPI_LOADER_CHECKSUM_EN
   ,output logic [7:0]        ioctl_sum
`endif
);

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

    logic         byte_valid, ss_active;
    logic [7:0]   rx_byte;
    ioctl_state_t state, state_nxt;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .spi_sck    (SPI_SCK),
        .spi_ss     (SPI_SS2),
        .spi_di     (SPI_DI),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .ss_active  (ss_active)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_CMD;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!ss_active) begin
            state_nxt = S_CMD;
        end else if (byte_valid) begin
            case (state)
                S_CMD: begin
                    case (rx_byte)
                        CMD_FILE_TX:     state_nxt = S_CTRL;
                        CMD_FILE_TX_DAT: state_nxt = S_DATA;
                        CMD_FILE_INDEX:  state_nxt = S_INDEX;
                        default:         state_nxt = S_CMD;
                    endcase
                end
                S_CTRL:  state_nxt = S_CMD;
                S_INDEX: state_nxt = S_CMD;
                S_DATA:  state_nxt = S_DATA;
                default: state_nxt = S_CMD;
            endcase
        end
    end

    // Address advances the cycle after a strobe so addr/dout hold while wr is high.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ioctl_download <= 1'b0;
            ioctl_index    <= 8'd0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= START;
            ioctl_dout     <= 8'd0;
        end else begin
            ioctl_wr <= 1'b0;
            if (ioctl_wr) ioctl_addr <= ioctl_addr + 1'b1;
            if (byte_valid && ss_active) begin
                case (state)
                    S_CTRL: begin
                        if (rx_byte != 8'd0) begin
                            ioctl_download <= 1'b1;
                            ioctl_addr     <= START;
                        end else begin
                            ioctl_download <= 1'b0;
                        end
                    end
                    S_INDEX: if (!ioctl_download) ioctl_index <= rx_byte;
                    S_DATA: begin
                        if (ioctl_download) begin
                            ioctl_dout <= rx_byte;
                            ioctl_wr   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IOCTL_SPI_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ioctl_sum <= 8'd0;
        end else if (byte_valid && ss_active && state == S_CTRL && rx_byte != 8'd0) begin
            ioctl_sum <= 8'd0;
        end else if (ioctl_wr) begin
            ioctl_sum <= ioctl_sum + ioctl_dout;
        end
    end
`endif

endmodule

// File: tb/tb_ioctl_spi_loader.sv
// Directed bench for ioctl_spi_loader; a second instance (ADDR_W=4, START_ADDR=14) covers wrap.
`timescale 1ns/1ps
module tb_ioctl_spi_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        SPI_SCK = 1'b0;
    logic        SPI_SS2 = 1'b1;
    logic        SPI_DI  = 1'b0;

    logic        ioctl_download, ioctl_wr;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        dl_w, wr_w;
    logic [7:0]  idx_w, dout_w;
    logic [3:0]  addr_w;
`ifdef IOCTL_SPI_LOADER_CHECKSUM_EN
    logic [7:0]  ioctl_sum, sum_w;
`endif

    int total = 0;
    int bad   = 0;

    int         q_addr[$];
    logic [7:0] q_dout[$];
    int         wq_addr[$];
    logic       prev_wr   = 1'b0;
    logic       b2b_err   = 1'b0;
    logic       watch_dl  = 1'b0;
    logic       dl_glitch = 1'b0;

    always #21 clk_sys = ~clk_sys;

    ioctl_spi_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout)
`ifdef IOCTL_SPI_LOADER_CHECKSUM_EN
       ,.ioctl_sum(ioctl_sum)
`endif
    );

    ioctl_spi_loader #(.ADDR_W(4), .START_ADDR(14)) dut_w (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .ioctl_download(dl_w), .ioctl_index(idx_w),
        .ioctl_wr(wr_w), .ioctl_addr(addr_w), .ioctl_dout(dout_w)
`ifdef IOCTL_SPI_LOADER_CHECKSUM_EN
       ,.ioctl_sum(sum_w)
`endif
    );

    always @(negedge clk_sys) begin
        if (ioctl_wr) begin
            q_addr.push_back(int'(ioctl_addr));
            q_dout.push_back(ioctl_dout);
        end
        if (wr_w) wq_addr.push_back(int'(addr_w));
        if (ioctl_wr && prev_wr) b2b_err = 1'b1;
        prev_wr = ioctl_wr;
        if (watch_dl && !ioctl_download) dl_glitch = 1'b1;
    end

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            SPI_DI = b[i];
            #125 SPI_SCK = 1'b1;
            #125 SPI_SCK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b [4], input int n);
        SPI_SS2 = 1'b0;
        #250;
        for (int i = 0; i < n; i++) send_bits(b[i], 8);
        #250 SPI_SS2 = 1'b1;
        #500;
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_dout.delete();
        wq_addr.delete();
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk_sys);
        #1;
        total++; if (ioctl_download !== 1'b0) begin bad++; $display("FAIL reset_download got=%0b exp=0", ioctl_download); end
        total++; if (ioctl_index !== 8'h00) begin bad++; $display("FAIL reset_index got=%0h exp=0", ioctl_index); end
        total++; if (ioctl_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%0b exp=0", ioctl_wr); end
        total++; if (ioctl_addr !== 25'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", ioctl_addr); end
        total++; if (ioctl_dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%0h exp=0", ioctl_dout); end
        total++; if (addr_w !== 4'd14) begin bad++; $display("FAIL reset_addr_w got=%0d exp=14", addr_w); end
        reset_n = 1'b1;
        repeat (6) @(posedge clk_sys);
    endtask

    task automatic test_basic();
        clear_q();
        send_frame('{8'h55, 8'h02, 8'h00, 8'h00}, 2);
        total++; if (ioctl_index !== 8'h02) begin bad++; $display("FAIL basic_index got=%0h exp=02", ioctl_index); end
        send_frame('{8'h53, 8'hFF, 8'h00, 8'h00}, 2);
        total++; if (ioctl_download !== 1'b1) begin bad++; $display("FAIL basic_dl_on got=%0b exp=1", ioctl_download); end
        send_frame('{8'h54, 8'hA5, 8'h3C, 8'h00}, 4);
        total++;
        if (q_addr.size() !== 3) begin
            bad++; $display("FAIL basic_strobes got=%0d exp=3", q_addr.size());
        end else if (q_addr[0] != 0 || q_dout[0] !== 8'hA5 || q_addr[1] != 1 || q_dout[1] !== 8'h3C ||
                     q_addr[2] != 2 || q_dout[2] !== 8'h00) begin
            bad++; $display("FAIL basic_data got=(%0d,%0h)(%0d,%0h)(%0d,%0h) exp=(0,a5)(1,3c)(2,0)",
                            q_addr[0], q_dout[0], q_addr[1], q_dout[1], q_addr[2], q_dout[2]);
        end
        send_frame('{8'h53, 8'h00, 8'h00, 8'h00}, 2);
        total++; if (ioctl_download !== 1'b0) begin bad++; $display("FAIL basic_dl_off got=%0b exp=0", ioctl_download); end
    endtask

    task automatic test_data_before_start();
        clear_q();
        send_frame('{8'h54, 8'h77, 8'h00, 8'h00}, 2);
        total++; if (q_addr.size() !== 0) begin bad++; $display("FAIL nostart_strobes got=%0d exp=0", q_addr.size()); end
        total++; if (ioctl_addr !== 25'd3) begin bad++; $display("FAIL nostart_addr got=%0d exp=3", ioctl_addr); end
        total++; if (addr_w !== 4'd1) begin bad++; $display("FAIL nostart_addr_w got=%0d exp=1", addr_w); end
    endtask

    task automatic test_partial_byte();
        send_frame('{8'h53, 8'h01, 8'h00, 8'h00}, 2);
        clear_q();
        send_frame('{8'h54, 8'hA1, 8'h00, 8'h00}, 2);
        SPI_SS2 = 1'b0;
        #250;
        send_bits(8'h54, 8);
        send_bits(8'hFF, 5);
        #250 SPI_SS2 = 1'b1;
        #500;
        total++; if (q_addr.size() !== 1) begin bad++; $display("FAIL partial_nostrobe got=%0d exp=1", q_addr.size()); end
        send_frame('{8'h54, 8'h11, 8'h00, 8'h00}, 2);
        total++;
        if (q_addr.size() !== 2) begin
            bad++; $display("FAIL partial_next got=%0d strobes exp=2", q_addr.size());
        end else if (q_addr[1] != 1 || q_dout[1] !== 8'h11) begin
            bad++; $display("FAIL partial_next got=(%0d,%0h) exp=(1,11)", q_addr[1], q_dout[1]);
        end
    endtask

    task automatic test_latency();
        int  cnt;
        logic found;
        cnt = 0;
        found = 1'b0;
        SPI_SS2 = 1'b0;
        #250;
        send_bits(8'h54, 8);
        send_bits(8'h5A, 7);
        SPI_DI = 1'b0;
        @(posedge clk_sys);
        #1 SPI_SCK = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk_sys);
            #1;
            cnt++;
            if (ioctl_wr) found = 1'b1;
        end
        total++; if (!found || cnt != 3) begin bad++; $display("FAIL latency got=%0d found=%0b exp=3", cnt, found); end
        total++; if (ioctl_dout !== 8'h5A) begin bad++; $display("FAIL latency_dout got=%0h exp=5a", ioctl_dout); end
        #20 SPI_SCK = 1'b0;
        #250 SPI_SS2 = 1'b1;
        #500;
    endtask

    task automatic test_wrap();
        send_frame('{8'h53, 8'h01, 8'h00, 8'h00}, 2);
        clear_q();
        send_frame('{8'h54, 8'h01, 8'h02, 8'h03}, 4);
        total++;
        if (wq_addr.size() !== 3) begin
            bad++; $display("FAIL wrap_count got=%0d exp=3", wq_addr.size());
        end else if (wq_addr[0] != 14 || wq_addr[1] != 15 || wq_addr[2] != 0) begin
            bad++; $display("FAIL wrap_addr got=%0d,%0d,%0d exp=14,15,0", wq_addr[0], wq_addr[1], wq_addr[2]);
        end
        total++; if (addr_w !== 4'd1) begin bad++; $display("FAIL wrap_after got=%0d exp=1", addr_w); end
        total++; if (ioctl_addr !== 25'd3) begin bad++; $display("FAIL wrap_main_addr got=%0d exp=3", ioctl_addr); end
    endtask

    task automatic test_restart();
        watch_dl = 1'b1;
        send_frame('{8'h53, 8'h02, 8'h00, 8'h00}, 2);
        watch_dl = 1'b0;
        total++; if (dl_glitch !== 1'b0) begin bad++; $display("FAIL restart_glitch got=%0b exp=0", dl_glitch); end
        total++; if (ioctl_addr !== 25'd0) begin bad++; $display("FAIL restart_addr got=%0d exp=0", ioctl_addr); end
        total++; if (addr_w !== 4'd14) begin bad++; $display("FAIL restart_addr_w got=%0d exp=14", addr_w); end
    endtask

`ifdef IOCTL_SPI_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        send_frame('{8'h53, 8'h01, 8'h00, 8'h00}, 2);
        send_frame('{8'h54, 8'hF0, 8'h20, 8'h01}, 4);
        total++; if (ioctl_sum !== 8'h11) begin bad++; $display("FAIL sum got=%0h exp=11", ioctl_sum); end
        send_frame('{8'h53, 8'h01, 8'h00, 8'h00}, 2);
        total++; if (ioctl_sum !== 8'h00) begin bad++; $display("FAIL sum_clear got=%0h exp=0", ioctl_sum); end
    endtask
`endif

    task automatic test_reset_mid();
        send_frame('{8'h53, 8'h01, 8'h00, 8'h00}, 2);
        SPI_SS2 = 1'b0;
        #250;
        send_bits(8'h54, 8);
        send_bits(8'hFF, 4);
        clear_q();
        #60 reset_n = 1'b0;
        #1;
        total++; if (ioctl_download !== 1'b0) begin bad++; $display("FAIL rstmid_dl got=%0b exp=0", ioctl_download); end
        total++; if (ioctl_addr !== 25'd0) begin bad++; $display("FAIL rstmid_addr got=%0d exp=0", ioctl_addr); end
        total++; if (addr_w !== 4'd14) begin bad++; $display("FAIL rstmid_addr_w got=%0d exp=14", addr_w); end
        #100 reset_n = 1'b1;
        send_bits(8'hFF, 4);
        send_bits(8'h99, 8);
        #250 SPI_SS2 = 1'b1;
        #500;
        total++; if (q_addr.size() !== 0) begin bad++; $display("FAIL rstmid_nostrobe got=%0d exp=0", q_addr.size()); end
        send_frame('{8'h55, 8'h07, 8'h00, 8'h00}, 2);
        total++; if (ioctl_index !== 8'h07) begin bad++; $display("FAIL rstmid_rearm got=%0h exp=07", ioctl_index); end
    endtask

    task automatic test_back_to_back();
        total++; if (b2b_err !== 1'b0) begin bad++; $display("FAIL back_to_back got=%0b exp=0", b2b_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_data_before_start();
        test_partial_byte();
        test_latency();
        test_wrap();
        test_restart();
`ifdef IOCTL_SPI_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
